// File: rtl/cordic_rsp_buffer_if.sv
// Stream and credit signals between the CORDIC core tap, the result FIFO and its consumer.
// Signal names are seen from the buffer: i_* flow into it and o_* flow out of it.
interface cordic_rsp_buffer_if #(
  parameter int TOTAL_WIDTH = 49,
  parameter int DEPTH       = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   i_issue;
  logic                   o_can_issue;
  logic                   i_vld;
  logic [TOTAL_WIDTH-1:0] i_data;
  logic                   o_vld;
  logic [TOTAL_WIDTH-1:0] o_data;
  logic                   i_rdy;
  logic [CW-1:0]          o_count;
  logic [2:0]             o_err;
  logic                   i_clr_err;

  modport slave (
    input  i_issue, i_vld, i_data, i_rdy, i_clr_err,
    output o_can_issue, o_vld, o_data, o_count, o_err
  );

  modport master (
    output i_issue, i_vld, i_data, i_rdy, i_clr_err,
    input  o_can_issue, o_vld, o_data, o_count, o_err
  );
endinterface

// File: rtl/cordic_rsp_buffer.sv
// Result FIFO behind the CORDIC core. The core cannot be stalled, so an in-flight credit
// counter throttles the issuer and every returning beat is guaranteed a free slot.
module cordic_rsp_buffer #(
  parameter int TOTAL_WIDTH = 49,
  parameter int DEPTH       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cordic_rsp_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int IW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(DEPTH);

  logic [TOTAL_WIDTH-1:0] mem_q [DEPTH];
  logic [TOTAL_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [IW-1:0]          inflight_q, inflight_d;
  logic [2:0]             err_q, err_d;

  logic       head_vld, full, push_ok, pop, orphan, can_issue;
  logic [2:0] err_evt;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    head_vld  = (count_q != '0);
    full      = (count_q == DEPTH_C);
    pop       = head_vld && bus.i_rdy;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    push_ok   = bus.i_vld && (!full || pop);
    orphan    = bus.i_vld && (inflight_q == '0);
    can_issue = (({2'b00, count_q} + {1'b0, inflight_q}) < DEPTH_W);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = bus.i_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Issue and return in the same cycle cancel out; otherwise saturate high, floor at zero.
    inflight_d = inflight_q;
    case ({bus.i_issue, bus.i_vld})
      2'b10:   if (inflight_q != '1) inflight_d = inflight_q + IW'(1);
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    err_evt = {bus.i_issue && !can_issue, orphan, bus.i_vld && full && !pop};
    err_d   = (bus.i_clr_err ? 3'b000 : err_q) | err_evt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: storage is reset too, so o_data reads zero after reset instead of stale words.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_vld       = head_vld;
  assign bus.o_data      = mem_q[rd_ptr_q];
  assign bus.o_count     = count_q;
  assign bus.o_err       = err_q;
  assign bus.o_can_issue = can_issue;
endmodule
